// File: rtl/fb_pkg.sv
// Shared constants and types for the frame-buffer port arbiter.
package fb_pkg;

   localparam int unsigned FB_NUM_PIX = 76800;
   localparam int unsigned FB_ADDR_W  = 17;
   localparam int unsigned FB_PIX_W   = 12;

   typedef enum logic [1:0] {
      REQ_W  = 2'd0,
      REQ_R0 = 2'd1,
      REQ_R1 = 2'd2
   } req_id_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clr_state_t;

endpackage

// File: rtl/fb_port_arbiter_rr_arb3.sv
// Three-way round-robin arbiter (W, R0, R1) with an optional writer-priority override.
module rr_arb3
   import fb_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       en_i,
   input  logic       prio_w_i,
   input  logic [2:0] req_i,
   output logic [2:0] gnt_o
);

   req_id_t    last_q;
   req_id_t    last_d;
   req_id_t    o0_s;
   req_id_t    o1_s;
   req_id_t    o2_s;
   logic [2:0] mask_s;

   // Search starts one past the last granted requester.
   always_comb begin
      gnt_o  = 3'b000;
      last_d = last_q;
      o0_s   = REQ_W;
      o1_s   = REQ_R0;
      o2_s   = REQ_R1;
      mask_s = prio_w_i ? {req_i[2:1], 1'b0} : req_i;
      case (last_q)
         REQ_W: begin
            o0_s = REQ_R0;
            o1_s = REQ_R1;
            o2_s = REQ_W;
         end
         REQ_R0: begin
            o0_s = REQ_R1;
            o1_s = REQ_W;
            o2_s = REQ_R0;
         end
         default: begin
            o0_s = REQ_W;
            o1_s = REQ_R0;
            o2_s = REQ_R1;
         end
      endcase
      if (!en_i) begin
         gnt_o = 3'b000;
      end else if (prio_w_i && req_i[0]) begin
         gnt_o = 3'b001;
      end else if (mask_s[o0_s]) begin
         gnt_o[o0_s] = 1'b1;
      end else if (mask_s[o1_s]) begin
         gnt_o[o1_s] = 1'b1;
      end else if (mask_s[o2_s]) begin
         gnt_o[o2_s] = 1'b1;
      end else begin
         gnt_o = 3'b000;
      end
      // Under writer priority the pointer only rotates between the readers.
      if (gnt_o[1]) begin
         last_d = REQ_R0;
      end else if (gnt_o[2]) begin
         last_d = REQ_R1;
      end else if (gnt_o[0] && !prio_w_i) begin
         last_d = REQ_W;
      end else begin
         last_d = last_q;
      end
   end

   // Pointer register; reset to R1 so the writer is first in line.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         last_q <= REQ_R1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/fb_port_arbiter.sv
// Frame BRAM port arbiter: round-robin W/R0/R1 access plus a frame-clear engine.
// Build option: define WRITE_PRIORITY_EN to give the writer absolute priority over the readers.
module fb_port_arbiter
   import fb_pkg::*;
#(
   parameter int unsigned NUM_PIX = FB_NUM_PIX,
   parameter int unsigned ADDR_W  = FB_ADDR_W,
   parameter int unsigned PIX_W   = FB_PIX_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [PIX_W-1:0]  wr_data,
   input  logic              wr_last,
   output logic              wr_gnt,
   input  logic              rd0_req,
   input  logic [ADDR_W-1:0] rd0_addr,
   output logic              rd0_gnt,
   output logic              rd0_dvalid,
   output logic [PIX_W-1:0]  rd0_dout,
   input  logic              rd1_req,
   input  logic [ADDR_W-1:0] rd1_addr,
   output logic              rd1_gnt,
   output logic              rd1_dvalid,
   output logic [PIX_W-1:0]  rd1_dout,
   input  logic              clr_start,
   input  logic [PIX_W-1:0]  clr_value,
   output logic              clr_busy,
   output logic [7:0]        frame_count,
   output logic              addr_err,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [PIX_W-1:0]  mem_din,
   input  logic [PIX_W-1:0]  mem_dout
);

   localparam logic [ADDR_W-1:0] NUM_PIX_A = ADDR_W'(NUM_PIX);
   localparam logic [ADDR_W-1:0] LAST_A    = ADDR_W'(NUM_PIX - 1);

   clr_state_t        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [PIX_W-1:0]  val_q, val_d;
   logic [ADDR_W-1:0] addr_hold_q;
   logic [PIX_W-1:0]  din_hold_q;
   logic              rd0_dvalid_q, rd1_dvalid_q;
   logic              rd0_oor_q, rd1_oor_q;
   logic [7:0]        frame_q;
   logic              err_q;
   logic [2:0]        gnt_s;
   logic              arb_en_s;
   logic              prio_s;
   logic              wr_oor_s, rd0_oor_s, rd1_oor_s;

`ifdef WRITE_PRIORITY_EN
   assign prio_s = 1'b1;
`else
   assign prio_s = 1'b0;
`endif

   // A clear request in IDLE wins over any requester in the same cycle.
   assign arb_en_s  = (state_q == ST_IDLE) && !clr_start;
   assign wr_oor_s  = (wr_addr  >= NUM_PIX_A);
   assign rd0_oor_s = (rd0_addr >= NUM_PIX_A);
   assign rd1_oor_s = (rd1_addr >= NUM_PIX_A);

   rr_arb3 u_arb (
      .clk      (clk),
      .reset_n  (reset_n),
      .en_i     (arb_en_s),
      .prio_w_i (prio_s),
      .req_i    ({rd1_req, rd0_req, wr_req}),
      .gnt_o    (gnt_s)
   );

   assign wr_gnt      = gnt_s[0];
   assign rd0_gnt     = gnt_s[1];
   assign rd1_gnt     = gnt_s[2];
   assign clr_busy    = (state_q == ST_CLEAR);
   assign frame_count = frame_q;
   assign addr_err    = err_q;
   assign rd0_dvalid  = rd0_dvalid_q;
   assign rd1_dvalid  = rd1_dvalid_q;
   assign rd0_dout    = rd0_oor_q ? {PIX_W{1'b0}} : mem_dout;
   assign rd1_dout    = rd1_oor_q ? {PIX_W{1'b0}} : mem_dout;

   // Clear sequencer next state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      val_d   = val_q;
      case (state_q)
         ST_IDLE: begin
            if (clr_start) begin
               state_d = ST_CLEAR;
               cnt_d   = {ADDR_W{1'b0}};
               val_d   = clr_value;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            if (cnt_q == LAST_A) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // BRAM port mux; idle cycles replay the last address/data.
   always_comb begin
      mem_wr   = 1'b0;
      mem_addr = addr_hold_q;
      mem_din  = din_hold_q;
      if (state_q == ST_CLEAR) begin
         mem_wr   = 1'b1;
         mem_addr = cnt_q;
         mem_din  = val_q;
      end else if (gnt_s[0]) begin
         mem_wr   = !wr_oor_s;
         mem_addr = wr_addr;
         mem_din  = wr_data;
      end else if (gnt_s[1]) begin
         mem_addr = rd0_addr;
      end else if (gnt_s[2]) begin
         mem_addr = rd1_addr;
      end else begin
         mem_wr = 1'b0;
      end
   end

   // State, hold registers, read-return pipeline and status.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= {ADDR_W{1'b0}};
         val_q        <= {PIX_W{1'b0}};
         addr_hold_q  <= {ADDR_W{1'b0}};
         din_hold_q   <= {PIX_W{1'b0}};
         rd0_dvalid_q <= 1'b0;
         rd1_dvalid_q <= 1'b0;
         rd0_oor_q    <= 1'b0;
         rd1_oor_q    <= 1'b0;
         frame_q      <= 8'd0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         val_q        <= val_d;
         addr_hold_q  <= mem_addr;
         din_hold_q   <= mem_din;
         rd0_dvalid_q <= gnt_s[1];
         rd1_dvalid_q <= gnt_s[2];
         rd0_oor_q    <= rd0_oor_s;
         rd1_oor_q    <= rd1_oor_s;
         if (gnt_s[0] && wr_last) begin
            frame_q <= frame_q + 8'd1;
         end
         if ((gnt_s[0] && wr_oor_s) || (gnt_s[1] && rd0_oor_s) || (gnt_s[2] && rd1_oor_s)) begin
            err_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Randomized scoreboard bench for fb_port_arbiter with a behavioural BRAM and reference model.
module tb_fb_port_arbiter;
   import fb_pkg::*;

   localparam int NP = 76800;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        wr_req, wr_last, wr_gnt;
   logic [16:0] wr_addr;
   logic [11:0] wr_data;
   logic        rd0_req, rd0_gnt, rd0_dvalid;
   logic [16:0] rd0_addr;
   logic [11:0] rd0_dout;
   logic        rd1_req, rd1_gnt, rd1_dvalid;
   logic [16:0] rd1_addr;
   logic [11:0] rd1_dout;
   logic        clr_start, clr_busy, addr_err;
   logic [11:0] clr_value;
   logic [7:0]  frame_count;
   logic        mem_wr;
   logic [16:0] mem_addr;
   logic [11:0] mem_din, mem_dout;

   always #5 clk = ~clk;

   fb_port_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last), .wr_gnt(wr_gnt),
      .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_gnt(rd0_gnt), .rd0_dvalid(rd0_dvalid), .rd0_dout(rd0_dout),
      .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_gnt(rd1_gnt), .rd1_dvalid(rd1_dvalid), .rd1_dout(rd1_dout),
      .clr_start(clr_start), .clr_value(clr_value), .clr_busy(clr_busy),
      .frame_count(frame_count), .addr_err(addr_err),
      .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
   );

   // Behavioural BRAM: registered read, out-of-range reads return a nonzero pattern.
   logic [11:0] bram [NP];
   always @(posedge clk) begin
      if (mem_wr && mem_addr < 17'(NP)) bram[mem_addr] <= mem_din;
      mem_dout <= (mem_addr < 17'(NP)) ? bram[mem_addr] : 12'hFFF;
   end

   // Reference model state.
   logic [11:0] ref_mem [NP];
   int          m_last = 2;
   bit          m_busy = 0;
   int          m_cnt  = 0;
   logic [11:0] m_val  = 12'h000;
   int          m_fc   = 0;
   bit          m_err  = 0;
   int          cyc    = 0;
   int          n_chk  = 0;
   int          n_err  = 0;

   typedef struct { logic [11:0] d; int cyc; } exp_t;
   exp_t q0[$];
   exp_t q1[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Requester chosen by the stated arbitration rules; -1 when nobody is granted.
   function automatic int pick(input bit w, input bit r0, input bit r1, input int last);
      bit r [3];
      int idx;
      r[0] = w; r[1] = r0; r[2] = r1;
`ifdef WRITE_PRIORITY_EN
      if (w) return 0;
      for (int k = 1; k <= 3; k++) begin
         idx = (last + k) % 3;
         if (idx != 0 && r[idx]) return idx;
      end
`else
      for (int k = 1; k <= 3; k++) begin
         idx = (last + k) % 3;
         if (r[idx]) return idx;
      end
`endif
      return -1;
   endfunction

   // Model/stimulus side: predicts grants and memory traffic, queues read data.
   always @(negedge clk) begin
      int g;
      if (!reset_n) begin
         if (m_busy) ref_mem[m_cnt] = m_val;
         m_busy = 0; m_last = 2; m_fc = 0; m_err = 0;
         q0.delete(); q1.delete();
      end else begin
         chk("clr_busy", clr_busy, m_busy);
         chk("frame_count", frame_count, m_fc);
         chk("addr_err", addr_err, m_err);
         if (m_busy) begin
            chk("clr_no_gnt", {wr_gnt, rd0_gnt, rd1_gnt}, 0);
            chk("clr_mem_wr", mem_wr, 1);
            chk("clr_mem_addr", mem_addr, m_cnt);
            chk("clr_mem_din", mem_din, m_val);
            ref_mem[m_cnt] = m_val;
            m_cnt++;
            if (m_cnt == NP) m_busy = 0;
         end else if (clr_start) begin
            chk("start_no_gnt", {wr_gnt, rd0_gnt, rd1_gnt}, 0);
            m_busy = 1; m_cnt = 0; m_val = clr_value;
         end else begin
            g = pick(wr_req, rd0_req, rd1_req, m_last);
            chk("wr_gnt", wr_gnt, g == 0);
            chk("rd0_gnt", rd0_gnt, g == 1);
            chk("rd1_gnt", rd1_gnt, g == 2);
`ifdef WRITE_PRIORITY_EN
            if (g == 1 || g == 2) m_last = g;
`else
            if (g >= 0) m_last = g;
`endif
            if (g == 0) begin
               if (wr_addr < 17'(NP)) begin
                  chk("wr_mem_wr", mem_wr, 1);
                  chk("wr_mem_addr", mem_addr, wr_addr);
                  chk("wr_mem_din", mem_din, wr_data);
                  ref_mem[wr_addr] = wr_data;
               end else begin
                  chk("wr_oor_mem_wr", mem_wr, 0);
                  m_err = 1;
               end
               if (wr_last) m_fc = (m_fc + 1) % 256;
            end else if (g == 1) begin
               chk("rd0_mem_wr", mem_wr, 0);
               chk("rd0_mem_addr", mem_addr, rd0_addr);
               if (rd0_addr < 17'(NP)) q0.push_back('{ref_mem[rd0_addr], cyc});
               else begin q0.push_back('{12'h000, cyc}); m_err = 1; end
            end else if (g == 2) begin
               chk("rd1_mem_wr", mem_wr, 0);
               chk("rd1_mem_addr", mem_addr, rd1_addr);
               if (rd1_addr < 17'(NP)) q1.push_back('{ref_mem[rd1_addr], cyc});
               else begin q1.push_back('{12'h000, cyc}); m_err = 1; end
            end else begin
               chk("idle_mem_wr", mem_wr, 0);
            end
         end
      end
   end

   // Monitor: pops expected read data whenever a reader presents dvalid.
   always @(negedge clk) begin
      exp_t e;
      if (reset_n) begin
         if (rd0_dvalid) begin
            if (q0.size() == 0) chk("rd0_dvalid_spurious", 1, 0);
            else begin
               e = q0.pop_front();
               chk("rd0_latency", cyc, e.cyc + 1);
               chk("rd0_dout", rd0_dout, e.d);
            end
         end else if (q0.size() > 0 && q0[0].cyc < cyc) begin
            chk("rd0_dvalid_missing", 0, 1);
            void'(q0.pop_front());
         end
         if (rd1_dvalid) begin
            if (q1.size() == 0) chk("rd1_dvalid_spurious", 1, 0);
            else begin
               e = q1.pop_front();
               chk("rd1_latency", cyc, e.cyc + 1);
               chk("rd1_dout", rd1_dout, e.d);
            end
         end else if (q1.size() > 0 && q1[0].cyc < cyc) begin
            chk("rd1_dvalid_missing", 0, 1);
            void'(q1.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(input int which, input int bound, input string nm);
      bit got = 0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if ((which == 0 && wr_gnt) || (which == 1 && rd0_gnt) || (which == 2 && rd1_gnt)) begin
            got = 1;
            break;
         end
      end
      chk(nm, got, 1);
      tick();
   endtask

   task automatic do_write(input logic [16:0] a, input logic [11:0] d, input bit last);
      wr_req = 1; wr_addr = a; wr_data = d; wr_last = last;
      wait_gnt(0, 8, "wr_gnt_timeout");
      wr_req = 0; wr_last = 0;
   endtask

   task automatic do_read(input int port, input logic [16:0] a);
      if (port == 0) begin rd0_req = 1; rd0_addr = a; end
      else begin rd1_req = 1; rd1_addr = a; end
      wait_gnt(port + 1, 8, "rd_gnt_timeout");
      rd0_req = 0; rd1_req = 0;
   endtask

   function automatic logic [16:0] rand_addr();
      int sel = $urandom_range(0, 31);
      if (sel == 0) return 17'(NP + $urandom_range(0, 1000));
      if (sel < 5) return 17'($urandom_range(0, NP - 1));
      return 17'($urandom_range(0, 63));
   endfunction

   initial begin
      bit gw, g0, g1;
      for (int i = 0; i < NP; i++) begin
         bram[i]    = 12'(i * 7 + 3);
         ref_mem[i] = 12'(i * 7 + 3);
      end
      reset_n = 0; wr_req = 0; wr_addr = 0; wr_data = 0; wr_last = 0;
      rd0_req = 0; rd0_addr = 0; rd1_req = 0; rd1_addr = 0; clr_start = 0; clr_value = 0;
      repeat (3) tick();
      reset_n = 1;
      tick();

      // All three requesting continuously.
      wr_req = 1; wr_addr = 17'd5; wr_data = 12'h321;
      rd0_req = 1; rd0_addr = 17'd5; rd1_req = 1; rd1_addr = 17'd6;
      repeat (9) tick();
      wr_req = 0; rd0_req = 0; rd1_req = 0;
      repeat (2) tick();

      // Write then read back.
      do_write(17'd100, 12'hABC, 0);
      do_read(0, 17'd100);
      tick();

      // Full clear to zero; reader queued at the start cycle, second start ignored.
      clr_start = 1; clr_value = 12'h000; rd0_req = 1; rd0_addr = 17'd0;
      tick();
      clr_start = 0;
      repeat (10) tick();
      clr_start = 1; clr_value = 12'hFFF;
      tick();
      clr_start = 0;
      wait_gnt(1, 80000, "clear_end_timeout");
      rd0_req = 0;
      do_read(1, 17'd76799);
      do_read(0, 17'd100);

      // Out-of-range accesses.
      do_read(1, 17'd76800);
      do_write(17'd80000, 12'h123, 0);
      tick();

      // Frame counter wrap.
      for (int i = 0; i < 256; i++) do_write(17'($urandom_range(0, 63)), 12'($urandom), 1);
      tick();

      // Reset in the middle of a clear.
      clr_start = 1; clr_value = 12'h5A5;
      tick();
      clr_start = 0;
      repeat (50) tick();
      reset_n = 0;
      tick();
      reset_n = 1;
      tick();
      do_read(0, 17'd10);
      do_read(1, 17'd200);

      // W and R0 held together, then W drops.
      wr_req = 1; wr_addr = 17'd7; wr_data = 12'h777; rd0_req = 1; rd0_addr = 17'd7;
      repeat (5) tick();
      wr_req = 0;
      repeat (3) tick();
      rd0_req = 0;
      tick();

      // Random traffic honouring the hold-until-granted rule.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         gw = wr_gnt; g0 = rd0_gnt; g1 = rd1_gnt;
         tick();
         if (!wr_req || gw) begin
            wr_req = ($urandom_range(0, 2) != 0); wr_addr = rand_addr();
            wr_data = 12'($urandom); wr_last = ($urandom_range(0, 15) == 0);
         end
         if (!rd0_req || g0) begin rd0_req = ($urandom_range(0, 2) != 0); rd0_addr = rand_addr(); end
         if (!rd1_req || g1) begin rd1_req = ($urandom_range(0, 2) != 0); rd1_addr = rand_addr(); end
      end
      wr_req = 0; rd0_req = 0; rd1_req = 0;
      repeat (4) tick();
      chk("queues_drained", q0.size() + q1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
